// File: rtl/seg_display_pager.sv
// Multi-page 7-segment display controller with manual, step and timed
// page selection, per-page leading-zero blanking and whole-display blink.
module seg_display_pager #(
    parameter int DIGITS = 4,
    parameter int PAGES  = 4,
    parameter int DWELL  = 300,
    parameter int BLINK  = 50,
    parameter int PW     = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic [PAGES*DIGITS*4-1:0] page_bcd,
    input  logic [PAGES*DIGITS*7-1:0] page_raw,
    input  logic [PAGES*DIGITS-1:0] page_raw_en,
    input  logic [PAGES-1:0]        lz_blank,
    input  logic                    auto_rot,
    input  logic                    step,
    input  logic [PW-1:0]           page_sel,
    input  logic                    page_sel_valid,
    input  logic                    blink_en,
    output logic [DIGITS*7-1:0]     hex,
    output logic [PW-1:0]           page_cur
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int BW = (BLINK > 1) ? $clog2(BLINK) : 1;

    logic [DW-1:0] dwell;
    logic [BW-1:0] blink_cnt;
    logic          phase;
    logic          step_q;
    logic          step_edge;
    logic          dwell_wrap;
    logic [PW-1:0] page_inc;

    logic [DIGITS*7-1:0] hex_d;
    logic                lead;
    logic [3:0]          bcd;
    logic [6:0]          raw;
    logic                ren;
    logic [6:0]          glyph;
    int                  idx;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign step_edge  = step & ~step_q;
    assign dwell_wrap = auto_rot & clk_en & (dwell == DW'(DWELL - 1));
    assign page_inc   = (page_cur == PW'(PAGES - 1)) ? '0 : page_cur + 1'b1;

    // Page selection with priority strobe > step edge > auto wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            page_cur <= '0;
            dwell    <= '0;
            step_q   <= 1'b1;
        end else begin
            step_q <= step;
            if (page_sel_valid) begin
                if (int'(page_sel) < PAGES)
                    page_cur <= page_sel;
                dwell <= '0;
            end else if (step_edge) begin
                page_cur <= page_inc;
                dwell    <= '0;
            end else if (dwell_wrap) begin
                page_cur <= page_inc;
                dwell    <= '0;
            end else if (!auto_rot) begin
                dwell <= '0;
            end else if (clk_en) begin
                dwell <= dwell + 1'b1;
            end
        end
    end

    // Blink half-period counter; phase=1 means display blanked
    always_ff @(posedge clk) begin
        if (rst || !blink_en) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (clk_en) begin
            if (blink_cnt == BW'(BLINK - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Decode the current page, blanking leading zeros from the top digit
    always_comb begin
        hex_d = '1;
        lead  = 1'b1;
        bcd   = '0;
        raw   = '0;
        ren   = 1'b0;
        glyph = 7'h7F;
        idx   = 0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            idx = int'(page_cur) * DIGITS + d;
            bcd = page_bcd[idx*4 +: 4];
            raw = page_raw[idx*7 +: 7];
            ren = page_raw_en[idx];
            if (lz_blank[page_cur] && lead && !ren &&
                bcd == 4'd0 && d != 0) begin
                glyph = 7'h7F;
            end else begin
                lead  = 1'b0;
                glyph = ren ? ~raw : seg7(bcd);
            end
            if (!(blink_en && phase))
                hex_d[d*7 +: 7] = glyph;
        end
    end

    // Registered segment outputs
    always_ff @(posedge clk) begin
        if (rst)
            hex <= '1;
        else
            hex <= hex_d;
    end

endmodule

// File: tb/tb_seg_display_pager.sv
// Bench for seg_display_pager: directed literal checks followed by
// random stimulus compared every cycle against a behavioural model.
module tb_seg_display_pager;

    localparam int DIGITS = 4;
    localparam int PAGES  = 4;
    localparam int DWELL  = 3;
    localparam int BLINK  = 2;
    localparam int PW     = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_en = 1'b0;
    logic [PAGES*DIGITS*4-1:0] page_bcd = '0;
    logic [PAGES*DIGITS*7-1:0] page_raw = '0;
    logic [PAGES*DIGITS-1:0]   page_raw_en = '0;
    logic [PAGES-1:0]          lz_blank = '0;
    logic auto_rot = 1'b0;
    logic step = 1'b0;
    logic [PW-1:0] page_sel = '0;
    logic page_sel_valid = 1'b0;
    logic blink_en = 1'b0;
    logic [DIGITS*7-1:0] hex;
    logic [PW-1:0] page_cur;

    // second instance with 3 pages so an out-of-range select exists
    logic [1:0]  sel1 = '0;
    logic        sel_valid1 = 1'b0;
    logic        auto_rot1 = 1'b0;
    logic [13:0] hex1;
    logic [1:0]  page1;

    int checks = 0;
    int errors = 0;

    logic [6:0] gl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                            7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                            7'h46, 7'h21, 7'h06, 7'h0E};

    int m_page, m_dwell, m_bt;
    bit m_sq;
    logic [DIGITS*7-1:0] exp_hex;
    int exp_page;

    always #5 clk = ~clk;

    seg_display_pager #(
        .DIGITS(DIGITS), .PAGES(PAGES), .DWELL(DWELL), .BLINK(BLINK)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .page_bcd(page_bcd), .page_raw(page_raw),
        .page_raw_en(page_raw_en), .lz_blank(lz_blank),
        .auto_rot(auto_rot), .step(step), .page_sel(page_sel),
        .page_sel_valid(page_sel_valid), .blink_en(blink_en),
        .hex(hex), .page_cur(page_cur)
    );

    seg_display_pager #(
        .DIGITS(2), .PAGES(3), .DWELL(3), .BLINK(2)
    ) dut1 (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .page_bcd(24'h0), .page_raw(42'h0),
        .page_raw_en(6'h0), .lz_blank(3'h0),
        .auto_rot(auto_rot1), .step(1'b0), .page_sel(sel1),
        .page_sel_valid(sel_valid1), .blink_en(1'b0),
        .hex(hex1), .page_cur(page1)
    );

    // What the display must show for page p
    function automatic logic [DIGITS*7-1:0] disp(input int p,
                                                 input bit blank);
        logic [DIGITS*7-1:0] r;
        int keep;
        r = '1;
        if (blank) return r;
        keep = DIGITS - 1;
        if (lz_blank[p]) begin
            keep = 0;
            for (int d = 0; d < DIGITS; d++)
                if (page_raw_en[p*DIGITS+d] ||
                    page_bcd[(p*DIGITS+d)*4 +: 4] != 0)
                    keep = d;
        end
        for (int d = 0; d <= keep; d++) begin
            if (page_raw_en[p*DIGITS+d])
                r[d*7 +: 7] = ~page_raw[(p*DIGITS+d)*7 +: 7];
            else
                r[d*7 +: 7] = gl[page_bcd[(p*DIGITS+d)*4 +: 4]];
        end
        return r;
    endfunction

    // Behavioural model advanced on every clock edge
    always @(posedge clk) begin
        bit edg;
        if (rst) begin
            m_page = 0; m_dwell = 0; m_bt = 0; m_sq = 1'b1;
            exp_hex = '1;
        end else begin
            exp_hex = disp(m_page, blink_en && ((m_bt / BLINK) % 2 == 1));
            edg = step && !m_sq;
            m_sq = step;
            if (page_sel_valid) begin
                if (page_sel < PAGES) m_page = page_sel;
                m_dwell = 0;
            end else if (edg) begin
                m_page = (m_page + 1) % PAGES;
                m_dwell = 0;
            end else if (auto_rot && clk_en) begin
                m_dwell++;
                if (m_dwell == DWELL) begin
                    m_dwell = 0;
                    m_page = (m_page + 1) % PAGES;
                end
            end
            if (!auto_rot) m_dwell = 0;
            if (!blink_en) m_bt = 0;
            else if (clk_en) m_bt++;
        end
        exp_page = m_page;
    end

    // Compare DUT outputs against the model every cycle
    always @(negedge clk) begin
        checks++;
        if (hex !== exp_hex) begin
            errors++;
            $display("FAIL hex t=%0t got %h exp %h", $time, hex, exp_hex);
        end
        checks++;
        if (int'(page_cur) != exp_page || $isunknown(page_cur)) begin
            errors++;
            $display("FAIL page_cur t=%0t got %0d exp %0d",
                     $time, page_cur, exp_page);
        end
    end

    task automatic lit(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            clk_en = 1'b1;
            @(negedge clk);
            clk_en = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        for (int d = 0; d < DIGITS; d++)
            page_bcd[d*4 +: 4] = 4'(d + 1);
        for (int i = DIGITS; i < PAGES*DIGITS; i++)
            page_bcd[i*4 +: 4] = 4'($urandom_range(9));
        repeat (3) @(negedge clk);
        lit("reset_hex", 64'(hex), 64'(28'hFFFFFFF));
        lit("reset_page", 64'(page_cur), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        lit("decode_1234", 64'(hex),
            64'({7'h19, 7'h30, 7'h24, 7'h79}));

        auto_rot = 1'b1;
        tick(3);
        lit("auto_p1", 64'(page_cur), 64'd1);
        tick(3);
        lit("auto_p2", 64'(page_cur), 64'd2);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        lit("step_p3", 64'(page_cur), 64'd3);
        tick(2);
        lit("dwell_restart", 64'(page_cur), 64'd3);
        tick(1);
        lit("auto_wrap_p0", 64'(page_cur), 64'd0);

        auto_rot = 1'b0;
        page_sel = 2'd2;
        page_sel_valid = 1'b1;
        step = 1'b1;
        @(negedge clk);
        page_sel_valid = 1'b0;
        step = 1'b0;
        lit("sel_over_step", 64'(page_cur), 64'd2);

        lz_blank = 4'b0100;
        page_bcd[32 +: 16] = 16'h0000;
        @(negedge clk);
        lit("lz_all_zero", 64'(hex), 64'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
        page_bcd[32 +: 16] = 16'h0307;
        @(negedge clk);
        lit("lz_0307", 64'(hex), 64'({7'h7F, 7'h30, 7'h40, 7'h78}));
        page_bcd[32 +: 16] = 16'h0000;
        page_raw_en[11] = 1'b1;
        page_raw[77 +: 7] = 7'b1011100;
        @(negedge clk);
        lit("raw_msb_o", 64'(hex), 64'({7'h23, 7'h40, 7'h40, 7'h40}));

        blink_en = 1'b1;
        tick(2);
        lit("blink_blank1", 64'(hex), 64'(28'hFFFFFFF));
        tick(2);
        lit("blink_normal", 64'(hex), 64'({7'h23, 7'h40, 7'h40, 7'h40}));
        tick(2);
        lit("blink_blank2", 64'(hex), 64'(28'hFFFFFFF));
        blink_en = 1'b0;
        @(negedge clk);
        lit("blink_off", 64'(hex), 64'({7'h23, 7'h40, 7'h40, 7'h40}));

        sel1 = 2'd2;
        sel_valid1 = 1'b1;
        @(negedge clk);
        sel_valid1 = 1'b0;
        lit("p3_sel2", 64'(page1), 64'd2);
        lit("p3_hex", 64'(hex1), 64'({7'h40, 7'h40}));
        auto_rot1 = 1'b1;
        tick(2);
        sel1 = 2'd3;
        sel_valid1 = 1'b1;
        @(negedge clk);
        sel_valid1 = 1'b0;
        lit("p3_sel_oor", 64'(page1), 64'd2);
        tick(2);
        lit("p3_dwell_clr", 64'(page1), 64'd2);
        tick(1);
        lit("p3_wrap", 64'(page1), 64'd0);
        auto_rot1 = 1'b0;

        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(499) == 0);
            clk_en = ($urandom_range(2) == 0);
            if ($urandom_range(7) == 0) step = ~step;
            page_sel_valid = ($urandom_range(39) == 0);
            page_sel = 2'($urandom_range(3));
            if ($urandom_range(199) == 0) auto_rot = ~auto_rot;
            if ($urandom_range(59) == 0) blink_en = ~blink_en;
            if ($urandom_range(49) == 0)
                lz_blank = 4'($urandom_range(15));
            if ($urandom_range(29) == 0) begin
                for (int i = 0; i < PAGES*DIGITS; i++) begin
                    page_bcd[i*4 +: 4] = $urandom_range(1) == 0 ?
                        4'd0 : 4'($urandom_range(15));
                    page_raw[i*7 +: 7] = 7'($urandom_range(127));
                    page_raw_en[i] = ($urandom_range(7) == 0);
                end
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
